fpcvt_arbiter: RTL
==================

# fpcvt_arbiter

Shares one 12-bit-linear to 8-bit-floating-point conversion datapath among NREQ requesters. Round-robin arbitration selects one valid request per cycle. The chosen sample passes through a two-stage registered pipeline wrapped around the existing combinational converter `main`. The result leaves on a valid/ready output port tagged with the requester index. The block sits between the sample producers and the float consumer, and is the only instantiation point of the converter.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- IDW, 2, width of the requester index; must equal ceil(log2(NREQ)), minimum 1
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  bit i: requester i holds a sample
- req_data  input  12*NREQ  requester i sample at bits [12*i+11 : 12*i], two's complement
- req_ready  output  NREQ  one-hot or zero grant, combinational; a transfer occurs on bit i when req_valid[i] and req_ready[i] are both high at a clock edge
- out_valid  output  1  out_data/out_id hold a result
- out_data  output  8  {sign, exp[2:0], sig[3:0]}, identical to `main` output for the accepted sample
- out_id  output  IDW  index of the requester that supplied the sample
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high
- busy  output  1  high when either pipeline stage is occupied
- conv_count  output  16  count of completed output transfers, wraps at 0xFFFF to 0x0000

## Operation
- Stage S1 registers: s1_valid, s1_data[11:0], s1_id. S1 feeds `main` combinationally.
- Stage S2 registers: out_valid, out_data, out_id. S2 captures the `main` output and S1's id.
- Enable rules:
  - adv2 = !out_valid || out_ready
  - adv1 = !s1_valid || adv2
- When adv2 is high, S2 loads from S1, including s1_valid = 0, which empties S2.
- When adv1 is high, S1 loads the granted request, or goes empty if nothing is granted.
- Arbiter state: ptr[IDW-1:0], the highest-priority index.
  - Search order is ptr, ptr+1, … NREQ-1, 0, … ptr-1 (mod NREQ).
  - The first i with req_valid[i] wins.
  - req_ready[winner] = adv1; all other bits of req_ready are 0.
- When a grant transfers, ptr becomes (winner+1) mod NREQ. Otherwise ptr holds.
- No grant lock: the winner is recomputed every cycle.
- A requester must hold req_valid and its data stable until granted.
- Only valid indices 0..NREQ-1 are ever granted. ptr never exceeds NREQ-1.
- conv_count increments by 1 on each output transfer.

## Timing
- Reset values (while rst is high, and asynchronously on assertion):
  - s1_valid = 0, out_valid = 0, out_data = 0x00, out_id = 0
  - ptr = 0, conv_count = 0, req_ready = 0, busy = 0
- Reset mid-operation discards both in-flight samples; no output is produced for them.
- Latency: a sample accepted at edge k appears with out_valid = 1 after edge k+1. That is one cycle in S1, then S2 is valid in the next cycle.
- Throughput: one conversion per cycle while out_ready is held high.
- Backpressure:
  - When out_valid = 1 and out_ready = 0, S2 holds.
  - S1 still accepts a request if it is empty; then req_ready goes to 0 until S2 drains.
- Simultaneous output transfer and S1 refill in the same cycle is legal and loses nothing.
- out_data and out_id stay stable while out_valid = 1 and out_ready = 0.
- Single active requester: it is granted every cycle that adv1 = 1.

## Test plan
- Reset and idle: hold rst for 3 cycles, then release with all req_valid = 0. Required: out_valid, req_ready, busy, and conv_count stay 0 for 20 cycles.
- Conversion values through requester 0, with out_ready = 1:
  - 0x000 -> 0x00
  - 0x1A6 (422) -> 0x5D
  - 0xE5A (-422) -> 0xDD
  - 0x7FF -> 0x7F
  - each result arrives one cycle after its accept, with out_id = 0
- Round-robin with NREQ = 4: all four req_valid held high, out_ready = 1. Required grant sequence is 0,1,2,3,0,… with one grant per cycle. After 8 outputs, conv_count = 8 and the out_id order matches the grant order.
- Backpressure: requesters 1 and 3 active, out_ready low for 5 cycles.
  - Exactly 2 samples are accepted; req_ready then stays 0 and out_data is held stable.
  - Raising out_ready drains the held results in order with none lost or duplicated.
- Reset mid-stream: assert rst asynchronously while S1 and S2 are full. Required: out_valid drops immediately, ptr = 0, and the first post-reset grant goes to the lowest active index.
- conv_count wrap: force 65 536 output transfers. Required: conv_count reads 0x0000 after the last one.

Source files
------------

// File: rtl/fpcvt_arbiter.sv
// Round-robin front end that shares one 12-bit linear to 8-bit float converter among NREQ
// requesters, with a two-stage registered pipeline and a valid/ready result port.

// Combinational converter: two's complement in, {sign, exp[2:0], sig[3:0]} out, rounded on
// the first dropped bit and saturated to the largest code when the result would not fit.
module main (
    input  logic [11:0] lin_i,
    output logic [7:0]  fp_o
);
    logic        sign;
    logic [11:0] mag;
    logic [3:0]  lz;
    logic [2:0]  e;
    logic [3:0]  sig;
    logic        rnd;
    logic [4:0]  sum;
    logic [11:0] shifted;
    logic [11:0] rnd_sh;

    always_comb begin
        sign    = lin_i[11];
        mag     = sign ? (~lin_i + 12'd1) : lin_i;
        lz      = 4'd12;
        for (int b = 0; b < 12; b++) begin
            if (mag[b]) lz = 4'(11 - b);
        end
        e       = 3'd0;
        sig     = mag[3:0];
        rnd     = 1'b0;
        shifted = 12'd0;
        rnd_sh  = 12'd0;
        // lz == 0 only for -2048, whose magnitude needs 12 bits: saturate.
        if (lz == 4'd0) begin
            e   = 3'd7;
            sig = 4'hF;
        end else if (lz < 4'd8) begin
            e       = 3'(4'd8 - lz);
            shifted = mag >> e;
            sig     = shifted[3:0];
            rnd_sh  = mag >> (e - 3'd1);
            rnd     = rnd_sh[0];
        end
        sum = {1'b0, sig} + {4'd0, rnd};
        if (sum[4]) begin
            if (e == 3'd7) begin
                sig = 4'hF;
            end else begin
                e   = e + 3'd1;
                sig = sum[4:1];
            end
        end else begin
            sig = sum[3:0];
        end
        fp_o = {sign, e, sig};
    end
endmodule

// valid/ready: a beat moves on a rising clk edge where valid and ready are both high;
// the sender holds valid and its payload unchanged until that edge.
module fpcvt_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [12*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic [IDW-1:0]       out_id,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [15:0]          conv_count
);
    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_W = IDW'(NREQ - 1);

    logic           s1_valid_q;
    logic [11:0]    s1_data_q;
    logic [IDW-1:0] s1_id_q;
    logic           out_valid_q;
    logic [7:0]     out_data_q;
    logic [IDW-1:0] out_id_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [15:0]    conv_count_q;

    logic           adv1;
    logic           adv2;
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW:0]   idx;
    logic           grant;
    logic [11:0]    win_data;
    logic [7:0]     cvt_data;

    // Scan from the far end so the last hit is the one closest to ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (req_valid[idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[IDW-1:0];
            end
        end
    end

    assign adv2      = !out_valid_q || out_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign grant     = win_found && adv1 && !rst;
    assign req_ready = grant ? (NREQ'(1) << win_idx) : '0;
    assign win_data  = req_data[12*win_idx +: 12];
    assign ptr_d     = (win_idx == LAST_W) ? '0 : win_idx + 1'b1;

    main u_main (
        .lin_i (s1_data_q),
        .fp_o  (cvt_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_id_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= '0;
            ptr_q        <= '0;
            conv_count_q <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= grant;
                if (grant) begin
                    s1_data_q <= win_data;
                    s1_id_q   <= win_idx;
                    ptr_q     <= ptr_d;
                end
            end
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                out_data_q  <= cvt_data;
                out_id_q    <= s1_id_q;
            end
            if (out_valid_q && out_ready) conv_count_q <= conv_count_q + 16'd1;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_id     = out_id_q;
    assign busy       = s1_valid_q || out_valid_q;
    assign conv_count = conv_count_q;
endmodule
